// File: rtl/por_trim_pkg.sv
// Shared types and defaults for the power-on / soft-reset trim sequencer.
// Holds the sequencer state encoding and the default timing constants.
package por_trim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int HOLD_CYCLES_DEF    = 16;
    localparam int STAGGER_CYCLES_DEF = 8;

endpackage

// File: rtl/por_trim_timer.sv
// Cleared-on-load up-counter with a terminal-count flag.
// Ports: clk, load (clear to 0), en (increment), last (count == LIMIT-1).
module por_trim_timer #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic load,
    input  logic en,
    output logic last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // Flag is high when the next increment reaches LIMIT.
    assign last = (count == W'(LIMIT - 1));

endmodule

// File: rtl/por_trim_sequencer.sv
// Power-on / soft-reset sequencer: holds all domain resets, then releases
// them in staggered index order and latches the (optionally trimmed) vector.
// Ports: clk12, reset (sync, active high), req_reset, trim_vec, trim_ena,
//        domain_reset_o, reset_vector_o, busy, done, req_count.
module por_trim_sequencer
    import por_trim_pkg::*;
#(
    parameter int               NUM_DOMAINS    = 4,
    parameter int               VEC_W          = 32,
    parameter logic [VEC_W-1:0] DEFAULT_VEC    = VEC_W'(32'h6000_0000),
    parameter int               HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int               STAGGER_CYCLES = STAGGER_CYCLES_DEF,
    parameter int               CNT_W          = 16
) (
    input  logic                   clk12,
    input  logic                   reset,
    input  logic                   req_reset,
    input  logic [VEC_W-1:0]       trim_vec,
    input  logic                   trim_ena,
    output logic [NUM_DOMAINS-1:0] domain_reset_o,
    output logic [VEC_W-1:0]       reset_vector_o,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       req_count
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state;
    state_t                 state_d;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_d;
    logic [NUM_DOMAINS-1:0] domain_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   start_q;
    logic                   hold_load;
    logic                   hold_last;
    logic                   hold_fire;
    logic                   stag_load;
    logic                   stag_last;
    logic                   stag_fire;
    logic [VEC_W-1:0]       capture_vec;

    assign capture_vec = trim_ena ? trim_vec : DEFAULT_VEC;

    // start_q marks the first edge after reset as the start edge, so the
    // hold count restarts there exactly as it does for an accepted request.
    assign hold_load = reset | req_reset | start_q;
    assign hold_fire = (state == ASSERT) & ~hold_load & hold_last;

    assign stag_fire = (state == RELEASE) & ~req_reset
                     & (idx != LAST_IDX) & stag_last;
    assign stag_load = reset | req_reset | hold_fire | stag_fire;

    por_trim_timer #(
        .LIMIT (HOLD_CYCLES),
        .W     (HOLD_W)
    ) u_hold (
        .clk  (clk12),
        .load (hold_load),
        .en   (state == ASSERT),
        .last (hold_last)
    );

    por_trim_timer #(
        .LIMIT (STAGGER_CYCLES),
        .W     (STAG_W)
    ) u_stag (
        .clk  (clk12),
        .load (stag_load),
        .en   (state == RELEASE),
        .last (stag_last)
    );

    always_ff @(posedge clk12) begin
        if (reset) begin
            state          <= ASSERT;
            idx            <= '0;
            domain_reset_o <= '1;
            busy           <= 1'b1;
            done           <= 1'b0;
            req_count      <= '0;
            start_q        <= 1'b1;
            reset_vector_o <= capture_vec;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            domain_reset_o <= domain_d;
            busy           <= busy_d;
            done           <= done_d;
            start_q        <= 1'b0;
            if (req_reset) begin
                reset_vector_o <= capture_vec;
                if (req_count != '1) begin
                    req_count <= req_count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = IDLE;
            ASSERT:  if (hold_fire) state_d = RELEASE;
            RELEASE: if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (req_reset) begin
            state_d = ASSERT;
        end
    end

    // Next values of the registered outputs; idx holds the most recently
    // released domain while in RELEASE.
    always_comb begin
        domain_d = domain_reset_o;
        busy_d   = busy;
        done_d   = 1'b0;
        idx_d    = idx;
        if (req_reset) begin
            domain_d = '1;
            busy_d   = 1'b1;
            idx_d    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    domain_d = '0;
                    busy_d   = 1'b0;
                end
                ASSERT: begin
                    if (hold_fire) begin
                        domain_d[0] = 1'b0;
                        idx_d       = '0;
                    end
                end
                RELEASE: begin
                    if (idx == LAST_IDX) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else if (stag_fire) begin
                        idx_d           = idx + IDX_W'(1);
                        domain_d[idx_d] = 1'b0;
                    end
                end
                DONE: begin
                    domain_d = '0;
                    busy_d   = 1'b0;
                end
                default: begin
                    domain_d = '0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_por_trim_sequencer.sv
// Self-checking bench for por_trim_sequencer: a default instance and a
// minimal instance (1 domain, 1/1 timing, 2-bit counter) vs a timeline model.
module tb_por_trim_sequencer;

    localparam int N   = 4;
    localparam int H   = 16;
    localparam int S   = 8;
    localparam int CW  = 16;
    localparam int H1  = 1;
    localparam int S1  = 1;
    localparam int CW1 = 2;
    localparam logic [31:0] DEF = 32'h6000_0000;

    logic clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    logic        reset, req_reset, trim_ena;
    logic [31:0] trim_vec;
    logic [3:0]  dom;
    logic [31:0] vec;
    logic        busy, done;
    logic [15:0] cnt;

    logic        s_reset, s_req, s_ena;
    logic [31:0] s_trim;
    logic [0:0]  s_dom;
    logic [31:0] s_vec;
    logic        s_busy, s_done;
    logic [1:0]  s_cnt;

    int checks = 0;
    int passed = 0;

    por_trim_sequencer dut (
        .clk12          (clk12),
        .reset          (reset),
        .req_reset      (req_reset),
        .trim_vec       (trim_vec),
        .trim_ena       (trim_ena),
        .domain_reset_o (dom),
        .reset_vector_o (vec),
        .busy           (busy),
        .done           (done),
        .req_count      (cnt)
    );

    por_trim_sequencer #(
        .NUM_DOMAINS    (1),
        .HOLD_CYCLES    (H1),
        .STAGGER_CYCLES (S1),
        .CNT_W          (CW1)
    ) dut1 (
        .clk12          (clk12),
        .reset          (s_reset),
        .req_reset      (s_req),
        .trim_vec       (s_trim),
        .trim_ena       (s_ena),
        .domain_reset_o (s_dom),
        .reset_vector_o (s_vec),
        .busy           (s_busy),
        .done           (s_done),
        .req_count      (s_cnt)
    );

    // Timeline model: k counts edges since the start edge; every output is
    // a plain function of k and the schedule H + i*S.
    bit          m_rst = 1'b1;
    int          m_k = 0;
    int          m_cnt = 0;
    logic [31:0] e_vec;
    logic [3:0]  e_dom;
    logic        e_busy, e_done;
    logic [15:0] e_cnt;

    bit          m1_rst = 1'b1;
    int          m1_k = 0;
    int          m1_cnt = 0;
    logic [31:0] e1_vec;
    logic        e1_dom, e1_busy, e1_done;
    logic [1:0]  e1_cnt;

    always @(posedge clk12) begin
        if (reset) begin
            m_rst = 1'b1;
            m_cnt = 0;
            e_vec = trim_ena ? trim_vec : DEF;
        end else if (req_reset) begin
            m_rst = 1'b0;
            m_k   = 0;
            e_vec = trim_ena ? trim_vec : DEF;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else if (m_rst) begin
            m_rst = 1'b0;
            m_k   = 0;
        end else if (m_k < 100000) begin
            m_k++;
        end
        e_dom = '0;
        for (int i = 0; i < N; i++) e_dom[i] = m_rst || (m_k < H + i * S);
        e_busy = m_rst || (m_k <= H + (N - 1) * S);
        e_done = !m_rst && (m_k == H + (N - 1) * S + 1);
        e_cnt  = 16'(m_cnt);
    end

    always @(posedge clk12) begin
        if (s_reset) begin
            m1_rst = 1'b1;
            m1_cnt = 0;
            e1_vec = s_ena ? s_trim : DEF;
        end else if (s_req) begin
            m1_rst = 1'b0;
            m1_k   = 0;
            e1_vec = s_ena ? s_trim : DEF;
            if (m1_cnt < (1 << CW1) - 1) m1_cnt++;
        end else if (m1_rst) begin
            m1_rst = 1'b0;
            m1_k   = 0;
        end else if (m1_k < 100000) begin
            m1_k++;
        end
        e1_dom  = m1_rst || (m1_k < H1);
        e1_busy = m1_rst || (m1_k <= H1);
        e1_done = !m1_rst && (m1_k == H1 + 1);
        e1_cnt  = 2'(m1_cnt);
    end

    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_reset = 1'b1; trim_ena = 1'b0; trim_vec = $urandom;
        s_reset = 1'b1; s_req = 1'b1; s_ena = 1'b0; s_trim = $urandom;
        repeat (3) begin
            tick();
            checks++;
            if (dom !== 4'hf || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL reset_outs dom=%h busy=%b done=%b want f 1 0", dom, busy, done);
            else passed++;
            checks++;
            if (cnt !== 16'd0 || vec !== DEF || s_cnt !== 2'd0)
                $display("FAIL reset_cnt_vec cnt=%0d vec=%h s_cnt=%0d want 0 %h 0", cnt, vec, s_cnt, DEF);
            else passed++;
        end
        req_reset = 1'b0;
        s_req = 1'b0;
    endtask

    task automatic test_basic();
        int dones = 0;
        reset = 1'b0;
        for (int c = 0; c < 46; c++) begin
            tick();
            if (done) dones++;
            checks++;
            if (dom !== e_dom || busy !== e_busy || done !== e_done)
                $display("FAIL basic c=%0d dom=%h busy=%b done=%b want %h %b %b", c, dom, busy, done, e_dom, e_busy, e_done);
            else passed++;
        end
        checks++;
        if (dones !== 1 || vec !== DEF || busy !== 1'b0)
            $display("FAIL basic_end dones=%0d vec=%h busy=%b want 1 %h 0", dones, vec, busy, DEF);
        else passed++;
    endtask

    task automatic test_trim();
        reset = 1'b1; trim_ena = 1'b1; trim_vec = 32'h6000_0002;
        tick();
        tick();
        reset = 1'b0;
        trim_vec = 32'h1234_5678;
        trim_ena = 1'($urandom);
        for (int c = 0; c < 45; c++) begin
            tick();
            checks++;
            if (vec !== 32'h6000_0002 || dom !== e_dom || done !== e_done)
                $display("FAIL trim c=%0d vec=%h dom=%h done=%b want 60000002 %h %b", c, vec, dom, done, e_dom, e_done);
            else passed++;
        end
    endtask

    task automatic test_soft_idle();
        trim_ena = 1'($urandom);
        trim_vec = $urandom;
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        checks++;
        if (cnt !== 16'd1 || dom !== 4'hf || busy !== 1'b1 || vec !== e_vec)
            $display("FAIL soft_req cnt=%0d dom=%h busy=%b vec=%h want 1 f 1 %h", cnt, dom, busy, vec, e_vec);
        else passed++;
        for (int c = 1; c < 45; c++) begin
            tick();
            checks++;
            if (dom !== e_dom || busy !== e_busy || done !== e_done || cnt !== e_cnt)
                $display("FAIL soft c=%0d dom=%h busy=%b done=%b cnt=%0d want %h %b %b %0d", c, dom, busy, done, cnt, e_dom, e_busy, e_done, e_cnt);
            else passed++;
        end
    endtask

    task automatic test_restart();
        int dones = 0;
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        repeat (30) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dom !== 4'b1100 || dones !== 0)
            $display("FAIL pre_restart dom=%h dones=%0d want c 0", dom, dones);
        else passed++;
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        checks++;
        if (dom !== 4'hf || cnt !== 16'd3 || busy !== 1'b1)
            $display("FAIL restart dom=%h cnt=%0d busy=%b want f 3 1", dom, cnt, busy);
        else passed++;
        for (int c = 1; c < 46; c++) begin
            tick();
            if (done) dones++;
            checks++;
            if (dom !== e_dom || busy !== e_busy || done !== e_done)
                $display("FAIL restart c=%0d dom=%h busy=%b done=%b want %h %b %b", c, dom, busy, done, e_dom, e_busy, e_done);
            else passed++;
        end
        checks++;
        if (dones !== 1)
            $display("FAIL restart_dones got=%0d want 1", dones);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req_reset = ($urandom_range(0, 59) == 0);
            trim_ena  = 1'($urandom);
            trim_vec  = $urandom;
            tick();
            checks++;
            if (dom !== e_dom || busy !== e_busy || done !== e_done || vec !== e_vec || cnt !== e_cnt)
                $display("FAIL random c=%0d dom=%h busy=%b done=%b vec=%h cnt=%0d want %h %b %b %h %0d", c, dom, busy, done, vec, cnt, e_dom, e_busy, e_done, e_vec, e_cnt);
            else passed++;
        end
        reset = 1'b0;
        req_reset = 1'b0;
    endtask

    task automatic test_corner();
        s_ena = 1'b1;
        s_trim = $urandom;
        tick();
        s_reset = 1'b0;
        s_trim = $urandom;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (s_dom !== e1_dom || s_busy !== e1_busy || s_done !== e1_done || s_vec !== e1_vec)
                $display("FAIL corner c=%0d dom=%b busy=%b done=%b vec=%h want %b %b %b %h", c, s_dom, s_busy, s_done, s_vec, e1_dom, e1_busy, e1_done, e1_vec);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 5; r++) begin
            s_req = 1'b1;
            s_ena = 1'($urandom);
            s_trim = $urandom;
            tick();
            s_req = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (s_cnt !== e1_cnt || s_dom !== e1_dom || s_done !== e1_done || s_vec !== e1_vec)
                    $display("FAIL sat r=%0d c=%0d cnt=%0d dom=%b done=%b want %0d %b %b", r, c, s_cnt, s_dom, s_done, e1_cnt, e1_dom, e1_done);
                else passed++;
            end
        end
        checks++;
        if (s_cnt !== 2'd3)
            $display("FAIL sat_final cnt=%0d want 3", s_cnt);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; req_reset = 1'b0; trim_ena = 1'b0; trim_vec = '0;
        s_reset = 1'b1; s_req = 1'b0; s_ena = 1'b0; s_trim = '0;
        test_reset();
        test_basic();
        test_trim();
        test_soft_idle();
        test_restart();
        test_random();
        test_corner();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
